// File: rtl/tlp_split_pkg.sv
// Shared definitions for the TLP request splitter.
//   split_state_t : sequencer state (IDLE -> CALC -> ISSUE)
//   DW_BYTES      : bytes per doubleword
//   PAGE_BYTES    : largest request size and 4KB page size
//   be_lo_mask    : byte enables from a byte offset up to the top of a DW
//   be_hi_mask    : byte enables from the bottom of a DW up to a byte offset
package tlp_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } split_state_t;

    localparam int DW_BYTES   = 4;
    localparam int PAGE_BYTES = 4096;

    // Bytes off..3 of a DW enabled.
    function automatic logic [3:0] be_lo_mask(input logic [1:0] off);
        return 4'hF << off;
    endfunction

    // Bytes 0..last_off of a DW enabled.
    function automatic logic [3:0] be_hi_mask(input logic [1:0] last_off);
        return 4'hF >> (2'd3 - last_off);
    endfunction

endpackage

// File: rtl/tlp_be_calc.sv
// Combinational descriptor field generator.
//   off      in  2   byte offset of the chunk start within its DW
//   chunk    in  13  chunk size in bytes (0..4096)
//   length   out 10  length in DW (1024 encoded as 0)
//   first_be out 4   First DW BE
//   last_be  out 4   Last DW BE (0000 for single-DW TLPs)
module tlp_be_calc
    import tlp_split_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [12:0] chunk,
    output logic [9:0]  length,
    output logic [3:0]  first_be,
    output logic [3:0]  last_be
);

    logic [13:0] span;
    logic [13:0] dw_count;
    logic [1:0]  last_off;

    assign span     = {12'd0, off} + {1'b0, chunk};
    assign dw_count = (span + 14'd3) >> 2;
    // Offset of the last valid byte inside the last DW.
    assign last_off = span[1:0] - 2'd1;

    always_comb begin
        length   = 10'(dw_count);
        first_be = be_lo_mask(off);
        last_be  = be_hi_mask(last_off);
        if (chunk == 13'd0) begin
            // Zero-length transfer: one DW with no bytes enabled.
            length   = 10'd1;
            first_be = 4'b0000;
            last_be  = 4'b0000;
        end else if (dw_count == 14'd1) begin
            first_be = be_lo_mask(off) & be_hi_mask(last_off);
            last_be  = 4'b0000;
        end
    end

endmodule

// File: rtl/tlp_request_splitter.sv
// Splits one byte-granular memory request into DW-aligned TLP descriptors,
// never crossing a MAX_PAYLOAD_BYTES (write) / MAX_READ_BYTES (read) aligned
// boundary, and therefore never crossing a 4KB page.
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_addr, req_bytes, req_is_write)
//   req_err              one-cycle pulse when a request of >4096 bytes is dropped
//   tlp_valid/tlp_ready  descriptor handshake
//   tlp_addr, tlp_length, tlp_first_be, tlp_last_be, tlp_is_write, tlp_last
//   busy                 sequencer not idle
module tlp_request_splitter
    import tlp_split_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 256,
    parameter int MAX_READ_BYTES    = 512,
    parameter int ADDR_W            = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [12:0]       req_bytes,
    input  logic              req_is_write,
    output logic              req_err,
    output logic              tlp_valid,
    input  logic              tlp_ready,
    output logic [ADDR_W-1:0] tlp_addr,
    output logic [9:0]        tlp_length,
    output logic [3:0]        tlp_first_be,
    output logic [3:0]        tlp_last_be,
    output logic              tlp_is_write,
    output logic              tlp_last,
    output logic              busy
);

    localparam logic [12:0] WR_SZ    = 13'(MAX_PAYLOAD_BYTES);
    localparam logic [12:0] RD_SZ    = 13'(MAX_READ_BYTES);
    localparam logic [12:0] MAX_REQ  = 13'(PAGE_BYTES);

    split_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] cur_addr_reg;
    logic [12:0]       rem_bytes_reg;
    logic [12:0]       chunk_reg;
    logic              is_write_reg;

    logic [ADDR_W-1:0] tlp_addr_reg;
    logic [9:0]        tlp_length_reg;
    logic [3:0]        tlp_first_be_reg;
    logic [3:0]        tlp_last_be_reg;
    logic              tlp_is_write_reg;
    logic              tlp_last_reg;
    logic              req_err_reg;

    logic        req_accept;
    logic        req_oversize;
    logic [12:0] split_sz;
    logic [12:0] addr_off;
    logic [12:0] cap_bytes;
    logic [12:0] chunk;
    logic [9:0]  calc_length;
    logic [3:0]  calc_first_be;
    logic [3:0]  calc_last_be;

    assign req_ready    = (state_reg == ST_IDLE);
    assign busy         = (state_reg != ST_IDLE);
    // Derived straight from the state so an asynchronous reset drops it at once.
    assign tlp_valid    = (state_reg == ST_ISSUE);
    assign req_accept   = req_valid && req_ready;
    assign req_oversize = (req_bytes > MAX_REQ);

    // Bytes left before the next split-size aligned boundary.
    assign split_sz  = is_write_reg ? WR_SZ : RD_SZ;
    assign addr_off  = cur_addr_reg[12:0] & (split_sz - 13'd1);
    assign cap_bytes = split_sz - addr_off;
    assign chunk     = (rem_bytes_reg < cap_bytes) ? rem_bytes_reg : cap_bytes;

    tlp_be_calc u_be_calc (
        .off      (cur_addr_reg[1:0]),
        .chunk    (chunk),
        .length   (calc_length),
        .first_be (calc_first_be),
        .last_be  (calc_last_be)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (req_accept && !req_oversize) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tlp_ready) begin
                    state_next = tlp_last_reg ? ST_IDLE : ST_CALC;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            cur_addr_reg     <= '0;
            rem_bytes_reg    <= '0;
            chunk_reg        <= '0;
            is_write_reg     <= 1'b0;
            tlp_addr_reg     <= '0;
            tlp_length_reg   <= '0;
            tlp_first_be_reg <= '0;
            tlp_last_be_reg  <= '0;
            tlp_is_write_reg <= 1'b0;
            tlp_last_reg     <= 1'b0;
            req_err_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_err_reg <= req_accept && req_oversize;

            if (req_accept && !req_oversize) begin
                cur_addr_reg  <= req_addr;
                rem_bytes_reg <= req_bytes;
                is_write_reg  <= req_is_write;
            end

            if (state_reg == ST_CALC) begin
                chunk_reg        <= chunk;
                tlp_addr_reg     <= {cur_addr_reg[ADDR_W-1:2], 2'b00};
                tlp_length_reg   <= calc_length;
                tlp_first_be_reg <= calc_first_be;
                tlp_last_be_reg  <= calc_last_be;
                tlp_is_write_reg <= is_write_reg;
                tlp_last_reg     <= (chunk == rem_bytes_reg);
            end

            if (state_reg == ST_ISSUE && tlp_ready) begin
                cur_addr_reg  <= cur_addr_reg + ADDR_W'(chunk_reg);
                rem_bytes_reg <= rem_bytes_reg - chunk_reg;
            end
        end
    end

    assign req_err      = req_err_reg;
    assign tlp_addr     = tlp_addr_reg;
    assign tlp_length   = tlp_length_reg;
    assign tlp_first_be = tlp_first_be_reg;
    assign tlp_last_be  = tlp_last_be_reg;
    assign tlp_is_write = tlp_is_write_reg;
    assign tlp_last     = tlp_last_reg;

endmodule
